// File: rtl/bus_uart_responder.sv
// bus_uart_responder: memory-mapped UART with a TX FIFO and an RX holding register on the data bus
module bus_uart_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          TX_DEPTH    = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic [3:0]  wstrb_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wvalue_i,
  output logic [31:0] rvalue_o,
  output logic        tx_o,
  input  logic        rx_i
);
  localparam int AW = $clog2(TX_DEPTH);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t tx_st_q, tx_st_d, rx_st_q, rx_st_d;
  logic hit, wr, rd, push, full, empty, pop, pop_rx, w1c, deliver, ferr_set, load;
  logic [1:0] sel;
  logic [7:0] fifo_q [TX_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  logic [15:0] div_q, div_w;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_sh_q, rx_sh_d, rx_byte_q;
  logic [2:0] sync_q;
  logic rx_valid_q, ovr_q, drop_q, ferr_q, tx_end, rx_end, rx_half, rxd, fell;
  logic [31:0] status, rdata;
  logic unused_bits;
  assign unused_bits = ^{addr_i[1:0], wvalue_i[31:16]};
  assign hit    = enable_i & (addr_i[31:4] == BASE_ADDR[31:4]);
  assign wr     = hit & |wstrb_i;
  assign rd     = hit & (wstrb_i == 4'd0);
  assign sel    = addr_i[3:2];
  assign full   = cnt_q == (AW+1)'(TX_DEPTH);
  assign empty  = cnt_q == '0;
  assign push   = wr & (sel == 2'd0) & wstrb_i[0];
  assign pop_rx = rd & (sel == 2'd0);
  assign w1c    = wr & (sel == 2'd1) & wstrb_i[0];
  assign load   = deliver & (~rx_valid_q | pop_rx);
  assign div_w  = {wstrb_i[1] ? wvalue_i[15:8] : div_q[15:8], wstrb_i[0] ? wvalue_i[7:0] : div_q[7:0]};
  assign status = {25'd0, ferr_q, drop_q, tx_st_q != IDLE, ovr_q, rx_valid_q, empty, full};
  assign rdata  = sel == 2'd0 ? {24'd0, rx_byte_q} : sel == 2'd1 ? status :
                  sel == 2'd2 ? {16'd0, div_q} : 32'd0;
  assign tx_o   = tx_st_q == START ? 1'b0 : tx_st_q == DATA ? tx_sh_q[0] : 1'b1;
  assign tx_end = tx_cnt_q == tx_div_q - 16'd1;
  assign rxd    = sync_q[1];
  assign fell   = sync_q[2] & ~sync_q[1];
  assign rx_end  = rx_cnt_q == rx_div_q - 16'd1;
  assign rx_half = rx_cnt_q == (rx_div_q >> 1) - 16'd1;
  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q + 16'd1;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    tx_div_d = tx_div_q;
    pop      = 1'b0;
    case (tx_st_q)
      IDLE: begin
        tx_cnt_d = '0;
        pop      = ~empty;
        tx_st_d  = empty ? IDLE : START;
      end
      START: if (tx_end) begin
        tx_cnt_d = '0;
        tx_bit_d = '0;
        tx_st_d  = DATA;
      end
      DATA: if (tx_end) begin
        tx_cnt_d = '0;
        tx_sh_d  = tx_sh_q >> 1;
        tx_bit_d = tx_bit_q + 3'd1;
        tx_st_d  = tx_bit_q == 3'd7 ? STOP : DATA;
      end
      default: if (tx_end) begin
        tx_cnt_d = '0;
        pop      = ~empty;
        tx_st_d  = empty ? IDLE : START;
      end
    endcase
    // each frame runs at the divisor captured when its byte leaves the FIFO
    if (pop) begin
      tx_sh_d  = fifo_q[rp_q];
      tx_div_d = div_q;
    end
  end
  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_cnt_q + 16'd1;
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    rx_div_d = rx_div_q;
    deliver  = 1'b0;
    ferr_set = 1'b0;
    case (rx_st_q)
      IDLE: begin
        rx_cnt_d = '0;
        rx_div_d = fell ? div_q : rx_div_q;
        rx_st_d  = fell ? START : IDLE;
      end
      START: if (rx_half) begin
        rx_cnt_d = '0;
        rx_bit_d = '0;
        rx_st_d  = rxd ? IDLE : DATA;
      end
      DATA: if (rx_end) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rxd, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        rx_st_d  = rx_bit_q == 3'd7 ? STOP : DATA;
      end
      default: if (rx_end) begin
        deliver  = rxd;
        ferr_set = ~rxd;
        rx_st_d  = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk_i) if (push & ~full) fifo_q[wp_q] <= wvalue_i[7:0];
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wp_q       <= '0;
      rp_q       <= '0;
      cnt_q      <= '0;
      div_q      <= DEFAULT_DIV;
      tx_st_q    <= IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_div_q   <= DEFAULT_DIV;
      rx_st_q    <= IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_div_q   <= DEFAULT_DIV;
      sync_q     <= 3'b111;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
      ovr_q      <= 1'b0;
      drop_q     <= 1'b0;
      ferr_q     <= 1'b0;
      rvalue_o   <= '0;
    end else begin
      wp_q       <= wp_q + AW'(push & ~full);
      rp_q       <= rp_q + AW'(pop);
      cnt_q      <= cnt_q + (AW+1)'(push & ~full) - (AW+1)'(pop);
      if (wr & (sel == 2'd2) & |wstrb_i[1:0]) div_q <= div_w < 16'd4 ? 16'd4 : div_w;
      tx_st_q    <= tx_st_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_div_q   <= tx_div_d;
      rx_st_q    <= rx_st_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_div_q   <= rx_div_d;
      sync_q     <= {sync_q[1:0], rx_i};
      // a same-cycle DATA read frees the holding register before the new byte lands
      rx_byte_q  <= load ? rx_sh_q : rx_byte_q;
      rx_valid_q <= deliver | (rx_valid_q & ~pop_rx);
      ovr_q      <= (deliver & rx_valid_q & ~pop_rx) | (ovr_q & ~(w1c & wvalue_i[3]));
      drop_q     <= (push & full) | (drop_q & ~(w1c & wvalue_i[5]));
      ferr_q     <= ferr_set | (ferr_q & ~(w1c & wvalue_i[6]));
      rvalue_o   <= rd ? rdata : 32'd0;
    end
  end
endmodule
